sync_ram_ctrl: RTL

//  Synchronous, single-clock successor to the async RamChip: parametrised width/depth, byte-lane

---
 rtl/sync_ram_ctrl_pkg.sv | 26 ++
 rtl/sync_ram_ctrl_array.sv | 70 +++++++
 rtl/sync_ram_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sync_ram_ctrl_pkg.sv
// Shared definitions for the synchronous RAM controller: FSM encodings,
// size helpers and the decoded-access record.
package sync_ram_ctrl_pkg;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Minimum 1 so a single-word memory still gets a 1-bit index.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int lanes(input int word_w, input int byte_w);
    return word_w / byte_w;
  endfunction

  typedef struct packed {
    logic rd;   // accepted read, in or out of range
    logic wr;   // accepted in-range write
    logic oor;  // accepted access with address >= Depth
  } acc_t;

endpackage

// File: rtl/sync_ram_ctrl_array.sv
// Depth x WordSize storage split into per-byte-lane instances, each with its
// own write enable and a registered read port that holds between reads.
module sync_ram_ctrl_lane #(
  parameter int Width = 8,
  parameter int Depth = 256,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [Width-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Only the read register is reset; storage contents come from the sweep.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];

endmodule

module sync_ram_ctrl_array #(
  parameter int WordSize = 32,
  parameter int ByteSize = 8,
  parameter int Depth    = 256,
  parameter int AW       = 8,
  parameter int Lanes    = WordSize / ByteSize
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [Lanes-1:0]    be,
  input  logic [AW-1:0]       waddr,
  input  logic [WordSize-1:0] wdata,
  input  logic                re,
  input  logic [AW-1:0]       raddr,
  output logic [WordSize-1:0] rdata
);

  logic [Lanes-1:0][ByteSize-1:0] wd_lane, rd_lane;

  assign wd_lane = wdata;
  assign rdata   = rd_lane;

  for (genvar l = 0; l < Lanes; l++) begin : g_lane
    sync_ram_ctrl_lane #(
      .Width (ByteSize),
      .Depth (Depth),
      .AW    (AW)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we && be[l]),
      .waddr (waddr),
      .wdata (wd_lane[l]),
      .re    (re),
      .raddr (raddr),
      .rdata (rd_lane[l])
    );
  end

endmodule

// File: rtl/sync_ram_ctrl.sv
// Synchronous RAM controller: init sweep FSM, req/ready port, byte-lane
// writes, range check and a 1- or 2-cycle read-valid/error pipeline.
module sync_ram_ctrl
  import sync_ram_ctrl_pkg::*;
#(
  parameter int                  WordSize    = 32,
  parameter int                  ByteSize    = 8,
  parameter int                  Depth       = 256,
  parameter int                  AddressSize = 8,
  parameter int                  ReadLatency = 1,
  parameter logic [WordSize-1:0] FillValue   = '0
) (
  input  logic                                 Clock,
  input  logic                                 nReset,
  input  logic                                 Req,
  input  logic                                 WE,
  input  logic [AddressSize-1:0]               Address,
  input  logic [WordSize-1:0]                  WData,
  input  logic [lanes(WordSize,ByteSize)-1:0]  ByteEn,
  input  logic                                 Clear,
  output logic                                 Ready,
  output logic                                 RValid,
  output logic [WordSize-1:0]                  RData,
  output logic                                 Error
);

  localparam int LANES = lanes(WordSize, ByteSize);
  localparam int AW    = clog2(Depth);

  logic [0:0]          state;
  logic [AW-1:0]       ptr;
  logic                init, in_range;
  acc_t                acc;
  logic                arr_we, arr_re;
  logic [LANES-1:0]    arr_be;
  logic [AW-1:0]       arr_waddr;
  logic [WordSize-1:0] arr_wdata, arr_rdata, d1;
  logic                rd_oor;
  logic [ReadLatency:1] vld_pipe, err_pipe;

  assign init     = (state == ST_INIT);
  assign Ready    = !init;
  assign in_range = ({1'b0, Address} < (AddressSize+1)'(Depth));

  always_comb begin
    acc.rd  = Req && Ready && !WE;
    acc.wr  = Req && Ready && WE && in_range;
    acc.oor = Req && Ready && !in_range;
  end

  // Clear wins over sweep completion so a late Clear still restarts at 0.
  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else if (Clear) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else if (init) begin
      if (ptr == AW'(Depth - 1)) begin
        state <= ST_RUN;
        ptr   <= '0;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end

  assign arr_we    = init || acc.wr;
  assign arr_be    = init ? '1 : ByteEn;
  assign arr_waddr = init ? ptr : Address[AW-1:0];
  assign arr_wdata = init ? FillValue : WData;
  assign arr_re    = acc.rd && in_range;

  sync_ram_ctrl_array #(
    .WordSize (WordSize),
    .ByteSize (ByteSize),
    .Depth    (Depth),
    .AW       (AW),
    .Lanes    (LANES)
  ) u_array (
    .clk   (Clock),
    .rst_n (nReset),
    .we    (arr_we),
    .be    (arr_be),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (arr_re),
    .raddr (Address[AW-1:0]),
    .rdata (arr_rdata)
  );

  // Tracks whether the most recent read was out of range; updated only on
  // reads so the stage-1 data holds alongside the array read register.
  always_ff @(posedge Clock or negedge nReset)
    if (!nReset)     rd_oor <= 1'b0;
    else if (acc.rd) rd_oor <= !in_range;

  assign d1 = rd_oor ? '0 : arr_rdata;

  if (ReadLatency == 2) begin : g_lat2
    logic [WordSize-1:0] rdata_q;
    always_ff @(posedge Clock or negedge nReset)
      if (!nReset) begin
        vld_pipe <= '0;
        err_pipe <= '0;
        rdata_q  <= '0;
      end else begin
        vld_pipe <= {vld_pipe[1], acc.rd};
        err_pipe <= {err_pipe[1], acc.oor};
        if (vld_pipe[1]) rdata_q <= d1;
      end
    assign RData = rdata_q;
  end else begin : g_lat1
    always_ff @(posedge Clock or negedge nReset)
      if (!nReset) begin
        vld_pipe <= '0;
        err_pipe <= '0;
      end else begin
        vld_pipe <= acc.rd;
        err_pipe <= acc.oor;
      end
    assign RData = d1;
  end

  assign RValid = vld_pipe[ReadLatency];
  assign Error  = err_pipe[ReadLatency];

endmodule
